// File: rtl/port_protocol_checker.sv
// Egress-side protocol checker: flags data/address changes without ready and
// over-long ready runs per port, with saturating counters and first-error capture.
module port_protocol_checker #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int CNT_W       = 16,
  parameter int TS_W        = 32,
  parameter int MAX_RDY_CYC = 8,
  localparam int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        clear,
  input  logic [NUM_PORTS*DATA_W-1:0] data_out,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_out,
  input  logic [NUM_PORTS-1:0]        data_rdy,
  output logic [NUM_PORTS-1:0]        err_sticky,
  output logic                        err_any,
  output logic [NUM_PORTS*CNT_W-1:0]  xfer_cnt,
  output logic [NUM_PORTS*CNT_W-1:0]  viol_cnt,
  output logic                        first_err_valid,
  output logic [PORT_W-1:0]           first_err_port,
  output logic [2:0]                  first_err_type,
  output logic [TS_W-1:0]             first_err_time
);

  localparam int RUN_W = $clog2(MAX_RDY_CYC + 2);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_RDY_CYC);
  localparam logic [RUN_W-1:0] RUN_SAT   = RUN_W'(MAX_RDY_CYC + 1);

  logic                 primed_reg;
  logic [TS_W-1:0]      ts_reg;
  logic                 first_valid_reg;
  logic [PORT_W-1:0]    first_port_reg;
  logic [2:0]           first_type_reg;
  logic [TS_W-1:0]      first_time_reg;

  logic [NUM_PORTS-1:0] data_viol;
  logic [NUM_PORTS-1:0] addr_viol;
  logic [NUM_PORTS-1:0] ovr_viol;
  logic [NUM_PORTS-1:0] port_viol;

  logic [PORT_W-1:0]    hit_port;
  logic [2:0]           hit_type;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [DATA_W-1:0] data_cur;
    logic [ADDR_W-1:0] addr_cur;
    logic              rdy;
    logic [DATA_W-1:0] data_prev_reg;
    logic [ADDR_W-1:0] addr_prev_reg;
    logic [RUN_W-1:0]  run_reg;
    logic              ovr_done_reg;
    logic [CNT_W-1:0]  xfer_reg;
    logic [CNT_W-1:0]  viol_reg;
    logic              sticky_reg;

    assign data_cur = data_out[gi*DATA_W +: DATA_W];
    assign addr_cur = addr_out[gi*ADDR_W +: ADDR_W];
    assign rdy      = data_rdy[gi];

    assign data_viol[gi] = primed_reg & enable & ~rdy & (data_cur != data_prev_reg);
    assign addr_viol[gi] = primed_reg & enable & ~rdy & (addr_cur != addr_prev_reg);
    // A run already past the limit (e.g. built up while disabled) still flags once.
    assign ovr_viol[gi]  = primed_reg & enable & rdy & (run_reg >= RUN_LIMIT) & ~ovr_done_reg;
    assign port_viol[gi] = data_viol[gi] | addr_viol[gi] | ovr_viol[gi];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_prev_reg <= '0;
        addr_prev_reg <= '0;
        run_reg       <= '0;
        ovr_done_reg  <= 1'b0;
        xfer_reg      <= '0;
        viol_reg      <= '0;
        sticky_reg    <= 1'b0;
      end else begin
        data_prev_reg <= data_cur;
        addr_prev_reg <= addr_cur;
        if (rdy) begin
          if (run_reg != RUN_SAT) run_reg <= run_reg + 1'b1;
          if (ovr_viol[gi]) ovr_done_reg <= 1'b1;
        end else begin
          run_reg      <= '0;
          ovr_done_reg <= 1'b0;
        end
        if (clear) begin
          xfer_reg   <= '0;
          viol_reg   <= '0;
          sticky_reg <= 1'b0;
        end else begin
          if (enable && rdy && (xfer_reg != '1)) xfer_reg <= xfer_reg + 1'b1;
          if (port_viol[gi] && (viol_reg != '1)) viol_reg <= viol_reg + 1'b1;
          if (port_viol[gi]) sticky_reg <= 1'b1;
        end
      end
    end

    assign xfer_cnt[gi*CNT_W +: CNT_W] = xfer_reg;
    assign viol_cnt[gi*CNT_W +: CNT_W] = viol_reg;
    assign err_sticky[gi]              = sticky_reg;
  end

  // Descending scan so the lowest-indexed violating port wins.
  always_comb begin
    hit_port = '0;
    hit_type = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (port_viol[p]) begin
        hit_port = PORT_W'(p);
        hit_type = {ovr_viol[p], addr_viol[p], data_viol[p]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      primed_reg      <= 1'b0;
      ts_reg          <= '0;
      first_valid_reg <= 1'b0;
      first_port_reg  <= '0;
      first_type_reg  <= '0;
      first_time_reg  <= '0;
    end else begin
      primed_reg <= 1'b1;
      if (clear) begin
        ts_reg          <= '0;
        first_valid_reg <= 1'b0;
        first_port_reg  <= '0;
        first_type_reg  <= '0;
        first_time_reg  <= '0;
      end else begin
        ts_reg <= ts_reg + 1'b1;
        if (!first_valid_reg && (|port_viol)) begin
          first_valid_reg <= 1'b1;
          first_port_reg  <= hit_port;
          first_type_reg  <= hit_type;
          first_time_reg  <= ts_reg;
        end
      end
    end
  end

  assign err_any         = |err_sticky;
  assign first_err_valid = first_valid_reg;
  assign first_err_port  = first_port_reg;
  assign first_err_type  = first_type_reg;
  assign first_err_time  = first_time_reg;

endmodule

// File: tb/tb_port_protocol_checker.sv
// Scoreboard bench for port_protocol_checker: expectations are queued as stimulus
// is driven and popped after the sampling edge.
module tb_port_protocol_checker;
  localparam int NP = 4;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int CW = 16;
  localparam int TW = 32;
  localparam int SCW = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic clear;
  logic [NP*DW-1:0] data_out;
  logic [NP*AW-1:0] addr_out;
  logic [NP-1:0]    data_rdy;

  logic [NP-1:0]    err_sticky;
  logic             err_any;
  logic [NP*CW-1:0] xfer_cnt;
  logic [NP*CW-1:0] viol_cnt;
  logic             first_err_valid;
  logic [1:0]       first_err_port;
  logic [2:0]       first_err_type;
  logic [TW-1:0]    first_err_time;

  logic [NP-1:0]     s_err_sticky;
  logic              s_err_any;
  logic [NP*SCW-1:0] s_xfer_cnt;
  logic [NP*SCW-1:0] s_viol_cnt;
  logic              s_first_err_valid;
  logic [1:0]        s_first_err_port;
  logic [2:0]        s_first_err_type;
  logic [TW-1:0]     s_first_err_time;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  port_protocol_checker #(
    .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .TS_W(TW), .MAX_RDY_CYC(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .data_out(data_out), .addr_out(addr_out), .data_rdy(data_rdy),
    .err_sticky(err_sticky), .err_any(err_any), .xfer_cnt(xfer_cnt), .viol_cnt(viol_cnt),
    .first_err_valid(first_err_valid), .first_err_port(first_err_port),
    .first_err_type(first_err_type), .first_err_time(first_err_time)
  );

  // Narrow-counter instance for the saturation scenario.
  port_protocol_checker #(
    .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .CNT_W(SCW), .TS_W(TW), .MAX_RDY_CYC(8)
  ) dut_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .data_out(data_out), .addr_out(addr_out), .data_rdy(data_rdy),
    .err_sticky(s_err_sticky), .err_any(s_err_any), .xfer_cnt(s_xfer_cnt), .viol_cnt(s_viol_cnt),
    .first_err_valid(s_first_err_valid), .first_err_port(s_first_err_port),
    .first_err_type(s_first_err_type), .first_err_time(s_first_err_time)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [15:0] d, input logic [15:0] a);
    data_out[p*DW +: DW] = d;
    addr_out[p*AW +: AW] = a;
  endtask

  function automatic logic [15:0] xfer_of(input int p);
    return xfer_cnt[p*CW +: CW];
  endfunction

  function automatic logic [15:0] viol_of(input int p);
    return viol_cnt[p*CW +: CW];
  endfunction

  // Absorb current inputs into the prev registers while disabled, then clear.
  task automatic prep();
    data_rdy = '0;
    enable   = 1'b0;
    tick();
    enable = 1'b1;
    clear  = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    reset_n = 1'b0; enable = 1'b1; clear = 1'b0;
    data_out = '0; addr_out = '0; data_rdy = '0;
    set_port(0, 16'hDEAD, 16'hBEEF);
    repeat (2) tick();
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); checks++;
    if ({err_sticky, err_any, xfer_cnt, viol_cnt, first_err_valid, first_err_port,
         first_err_type, first_err_time} !== '0 || 32'(err_any) !== e) begin
      errors++; $display("FAIL reset_outputs: got sticky=%b xfer=%h viol=%h valid=%b want all 0",
                         err_sticky, xfer_cnt, viol_cnt, first_err_valid);
    end else $display("reset_outputs: all zero");
    reset_n = 1'b1;
    tick();
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); checks++;
    if (32'(err_any) !== e) begin
      errors++; $display("FAIL first_cycle_no_err: got err_any=%0d want %0d", err_any, e);
    end else $display("first_cycle_no_err: err_any=%0d", err_any);
  endtask

  task automatic test_legal();
    logic [31:0] e;
    logic [15:0] d;
    logic [15:0] a;
    set_port(2, 16'h1234, 16'h0010);
    prep();
    for (int i = 0; i < 20; i++) begin
      d = (i % 2 == 0) ? 16'hBEEF : 16'h1234;
      a = (i % 2 == 0) ? 16'h0020 : 16'h0010;
      set_port(2, d, a);
      data_rdy[2] = 1'b1;
      exp_q.push_back(32'(i + 1));
      tick();
      data_rdy[2] = 1'b0;
      tick();
      e = exp_q.pop_front(); checks++;
      if (32'(xfer_of(2)) !== e) begin
        errors++; $display("FAIL legal_xfer%0d: got %0d want %0d", i, xfer_of(2), e);
      end else $display("legal_xfer%0d: xfer_cnt[2]=%0d", i, xfer_of(2));
    end
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); checks++;
    if (32'(viol_cnt) !== e || viol_cnt !== '0 || err_any !== 1'b0) begin
      errors++; $display("FAIL legal_no_viol: got viol=%h err_any=%0d want 0", viol_cnt, err_any);
    end else $display("legal_no_viol: viol_cnt=0 err_any=0");
  endtask

  task automatic test_data_viol();
    logic [31:0] e;
    set_port(1, 16'h00AA, 16'h0000);
    prep();
    repeat (37) tick();
    set_port(1, 16'h00AB, 16'h0000);
    exp_q.push_back(32'b0010); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    exp_q.push_back(32'b001);  exp_q.push_back(32'd37);
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(err_sticky) !== e) begin errors++; $display("FAIL dviol_sticky: got %b want %b", err_sticky, e[3:0]); end
    else $display("dviol_sticky: %b", err_sticky);
    e = exp_q.pop_front(); checks++;
    if (32'(viol_of(1)) !== e) begin errors++; $display("FAIL dviol_cnt1: got %0d want %0d", viol_of(1), e); end
    else $display("dviol_cnt1: %0d", viol_of(1));
    e = exp_q.pop_front(); checks++;
    if (32'(first_err_port) !== e || first_err_valid !== 1'b1) begin
      errors++; $display("FAIL dviol_port: got %0d valid=%0d want %0d valid=1", first_err_port, first_err_valid, e);
    end else $display("dviol_port: %0d", first_err_port);
    e = exp_q.pop_front(); checks++;
    if (32'(first_err_type) !== e) begin errors++; $display("FAIL dviol_type: got %b want %b", first_err_type, e[2:0]); end
    else $display("dviol_type: %b", first_err_type);
    e = exp_q.pop_front(); checks++;
    if (32'(first_err_time) !== e) begin errors++; $display("FAIL dviol_time: got %0d want %0d", first_err_time, e); end
    else $display("dviol_time: %0d", first_err_time);
    exp_q.push_back(32'd1);
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(viol_of(1)) !== e) begin errors++; $display("FAIL dviol_hold: got %0d want %0d", viol_of(1), e); end
    else $display("dviol_hold: %0d", viol_of(1));
  endtask

  task automatic test_simultaneous();
    logic [31:0] e;
    set_port(0, 16'h1111, 16'h2222);
    set_port(3, 16'h3333, 16'h4444);
    prep();
    set_port(0, 16'h1112, 16'h2223);
    set_port(3, 16'h3333, 16'h4445);
    exp_q.push_back(32'd0); exp_q.push_back(32'b011); exp_q.push_back(32'b1001);
    exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(first_err_port) !== e) begin errors++; $display("FAIL simul_port: got %0d want %0d", first_err_port, e); end
    else $display("simul_port: %0d", first_err_port);
    e = exp_q.pop_front(); checks++;
    if (32'(first_err_type) !== e) begin errors++; $display("FAIL simul_type: got %b want %b", first_err_type, e[2:0]); end
    else $display("simul_type: %b", first_err_type);
    e = exp_q.pop_front(); checks++;
    if (32'(err_sticky) !== e) begin errors++; $display("FAIL simul_sticky: got %b want %b", err_sticky, e[3:0]); end
    else $display("simul_sticky: %b", err_sticky);
    e = exp_q.pop_front(); checks++;
    if (32'(viol_of(0)) !== e) begin errors++; $display("FAIL simul_viol0: got %0d want %0d", viol_of(0), e); end
    else $display("simul_viol0: %0d", viol_of(0));
    e = exp_q.pop_front(); checks++;
    if (32'(viol_of(3)) !== e) begin errors++; $display("FAIL simul_viol3: got %0d want %0d", viol_of(3), e); end
    else $display("simul_viol3: %0d", viol_of(3));
  endtask

  task automatic test_overrun();
    logic [31:0] e;
    prep();
    data_rdy[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      exp_q.push_back((i >= 9) ? 32'd1 : 32'd0);
      exp_q.push_back(32'(i));
      tick();
      e = exp_q.pop_front(); checks++;
      if (32'(viol_of(0)) !== e) begin errors++; $display("FAIL ovr_viol_c%0d: got %0d want %0d", i, viol_of(0), e); end
      else $display("ovr_viol_c%0d: %0d", i, viol_of(0));
      e = exp_q.pop_front(); checks++;
      if (32'(xfer_of(0)) !== e) begin errors++; $display("FAIL ovr_xfer_c%0d: got %0d want %0d", i, xfer_of(0), e); end
      else $display("ovr_xfer_c%0d: %0d", i, xfer_of(0));
    end
    data_rdy[0] = 1'b0;
    exp_q.push_back(32'b100); exp_q.push_back(32'd8);
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(first_err_type) !== e || first_err_port !== 2'd0) begin
      errors++; $display("FAIL ovr_type: got %b port %0d want %b port 0", first_err_type, first_err_port, e[2:0]);
    end else $display("ovr_type: %b", first_err_type);
    e = exp_q.pop_front(); checks++;
    if (32'(first_err_time) !== e) begin errors++; $display("FAIL ovr_time: got %0d want %0d", first_err_time, e); end
    else $display("ovr_time: %0d", first_err_time);
  endtask

  task automatic test_clear_enable();
    logic [31:0] e;
    set_port(1, 16'h0001, 16'h0001);
    prep();
    set_port(1, 16'h0002, 16'h0001);
    data_rdy[0] = 1'b1;
    clear = 1'b1;
    exp_q.push_back(32'd0);
    tick();
    clear = 1'b0;
    data_rdy[0] = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (viol_cnt !== '0 || xfer_cnt !== '0 || first_err_valid !== 1'b0 || 32'(err_any) !== e) begin
      errors++; $display("FAIL clear_prio: got viol=%h xfer=%h valid=%0d want 0", viol_cnt, xfer_cnt, first_err_valid);
    end else $display("clear_prio: counters 0");
    enable = 1'b0;
    set_port(2, 16'h7777, 16'h8888);
    data_rdy[3] = 1'b1;
    exp_q.push_back(32'd0);
    tick();
    data_rdy[3] = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (viol_cnt !== '0 || xfer_cnt !== '0 || 32'(err_any) !== e) begin
      errors++; $display("FAIL disabled_hold: got viol=%h xfer=%h err_any=%0d want 0", viol_cnt, xfer_cnt, err_any);
    end else $display("disabled_hold: counters 0");
    data_rdy[0] = 1'b1;
    repeat (10) tick();
    enable = 1'b1;
    exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'b100);
    tick();
    data_rdy[0] = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (32'(viol_of(0)) !== e) begin errors++; $display("FAIL late_ovr_viol: got %0d want %0d", viol_of(0), e); end
    else $display("late_ovr_viol: %0d", viol_of(0));
    e = exp_q.pop_front(); checks++;
    if (32'(xfer_of(0)) !== e) begin errors++; $display("FAIL late_ovr_xfer: got %0d want %0d", xfer_of(0), e); end
    else $display("late_ovr_xfer: %0d", xfer_of(0));
    e = exp_q.pop_front(); checks++;
    if (32'(first_err_type) !== e) begin errors++; $display("FAIL late_ovr_type: got %b want %b", first_err_type, e[2:0]); end
    else $display("late_ovr_type: %b", first_err_type);
  endtask

  task automatic test_mid_reset();
    logic [31:0] e;
    prep();
    set_port(1, 16'h5A5A, 16'h0000);
    data_rdy[0] = 1'b1;
    exp_q.push_back(32'd1);
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(err_any) !== e) begin errors++; $display("FAIL pre_reset_err: got %0d want %0d", err_any, e); end
    else $display("pre_reset_err: %0d", err_any);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); checks++;
    if ({err_sticky, err_any, xfer_cnt, viol_cnt, first_err_valid, first_err_port,
         first_err_type, first_err_time} !== '0 || 32'(err_any) !== e) begin
      errors++; $display("FAIL async_reset: got sticky=%b xfer=%h viol=%h valid=%0d want all 0",
                         err_sticky, xfer_cnt, viol_cnt, first_err_valid);
    end else $display("async_reset: all zero");
    data_rdy = '0;
    set_port(3, 16'hC0DE, 16'hF00D);
    tick();
    reset_n = 1'b1;
    exp_q.push_back(32'd0);
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(err_any) !== e || first_err_valid !== 1'b0) begin
      errors++; $display("FAIL post_release: got err_any=%0d valid=%0d want 0", err_any, first_err_valid);
    end else $display("post_release: err_any=%0d", err_any);
  endtask

  task automatic test_saturation();
    logic [31:0] e;
    prep();
    data_rdy[0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      exp_q.push_back((i > 15) ? 32'd15 : 32'(i));
      tick();
      e = exp_q.pop_front(); checks++;
      if (32'(s_xfer_cnt[SCW-1:0]) !== e) begin
        errors++; $display("FAIL sat_xfer_c%0d: got %0d want %0d", i, s_xfer_cnt[SCW-1:0], e);
      end else $display("sat_xfer_c%0d: %0d", i, s_xfer_cnt[SCW-1:0]);
    end
    data_rdy[0] = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_legal();
    test_data_viol();
    test_simultaneous();
    test_overrun();
    test_clear_enable();
    test_mid_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/port_protocol_checker.md
# port_protocol_checker

Synthesizable, parametrised output-port protocol checker for the router's egress side. For each of `NUM_PORTS` channels it checks that `data_out` and `addr_out` change only on cycles where that port's `data_rdy` is high, and that `data_rdy` never stays high longer than `MAX_RDY_CYC` consecutive cycles. It counts transfers and violations per port, raises sticky error flags, and captures the first error with a timestamp. It sits beside the DUT in both simulation and emulation builds, so the checking does not depend on simulator assertions.

## Interface
- `NUM_PORTS`, 4, number of egress channels (1..16)
- `DATA_W`, 16, per-port data width
- `ADDR_W`, 16, per-port address width
- `CNT_W`, 16, width of each per-port counter (saturating)
- `TS_W`, 32, width of the cycle timestamp
- `MAX_RDY_CYC`, 8, longest legal run of consecutive `data_rdy` high cycles (≥1)

- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `enable` in 1: when high, checking and counting are active
- `clear` in 1: synchronous clear of counters, sticky flags and the capture
- `data_out` in NUM_PORTS*DATA_W: DUT data, port p at `[p*DATA_W +: DATA_W]`
- `addr_out` in NUM_PORTS*ADDR_W: DUT address, packed the same way
- `data_rdy` in NUM_PORTS: per-port ready
- `err_sticky` out NUM_PORTS: per-port sticky error flag
- `err_any` out 1: OR of `err_sticky`
- `xfer_cnt` out NUM_PORTS*CNT_W: per-port count of `data_rdy`-high cycles
- `viol_cnt` out NUM_PORTS*CNT_W: per-port count of violation cycles
- `first_err_valid` out 1: a first error has been captured
- `first_err_port` out $clog2(NUM_PORTS) (min 1): port index of the first error
- `first_err_type` out 3: bit0 data change, bit1 address change, bit2 ready overrun
- `first_err_time` out TS_W: timestamp value at the first error

## Operation
- **Sampling.** Each edge, every port registers `data_out`, `addr_out` and `data_rdy` into prev registers. This happens regardless of `enable` and `clear`.
- **Primed flag.** After reset, `primed` is 0. It sets on the first edge and stays set. No check fires while `primed`=0.
- **Data violation, port p.** `primed` & `enable` & `data_out[p]` ≠ prev & `data_rdy[p]`=0.
- **Address violation.** Same rule, applied to `addr_out`.
- **Ready run counter, per port.** Width `$clog2(MAX_RDY_CYC+2)`.
  - Increments while `data_rdy` is high and saturates at `MAX_RDY_CYC+1`.
  - Returns to 0 when `data_rdy` is low.
  - Overrun violation when the counter would reach `MAX_RDY_CYC+1` and `enable` is high. It is flagged once per run, on the first overrun cycle.
- **Violation cycle.** Any of the three violation kinds on port p in a cycle:
  - `viol_cnt[p]` += 1, counted once per cycle even if several kinds occur;
  - `err_sticky[p]` sets.
- **Transfer count.** When `enable` is high and `data_rdy[p]` is high, `xfer_cnt[p]` += 1.
- **Saturation.** Both counters saturate at all-ones.
- **Timestamp.** Free-running counter that increments every cycle and wraps. It is not affected by `enable`; it resets to 0 on `clear`.
- **First-error capture.** On the first violation cycle while `first_err_valid`=0:
  - latch the lowest-indexed violating port, its type bits (all kinds occurring that cycle on that port), and the current timestamp;
  - set `first_err_valid`.
- **While `enable` is low.** Counters, flags and the capture hold. The ready run counter still tracks, so an overrun started while disabled flags on the first enabled cycle past the limit.
- **`clear`.**
  - Zeroes `xfer_cnt`, `viol_cnt`, `err_sticky`, the capture and the timestamp.
  - Takes priority: violations and transfers in the same cycle are discarded.
  - Does not clear `primed`, the prev registers or the ready run counters.

## Timing
- Reset values: all outputs 0, `primed`=0, prev registers 0, run counters 0, timestamp 0.
- Latency is 1 cycle. A violation sampled at edge N shows on the counter, flag and capture outputs after edge N. `err_any` is combinational from `err_sticky`.
- `first_err_time` holds the timestamp value present before edge N, i.e. the offending cycle.
- Asserting `reset_n` low mid-run clears everything immediately. Checking resumes one edge after release.
- The timestamp wraps at 2^TS_W−1 → 0 with no flag.

## Test plan
- **Legal traffic.** NUM_PORTS=4. Port 2 drives data 0x1234→0xBEEF and addr 0x0010→0x0020 with `data_rdy[2]`=1 for one cycle, 20 times. Required: `xfer_cnt[2]`=20, all `viol_cnt`=0, `err_any`=0.
- **Data change without ready.** Port 1 data changes 0x00AA→0x00AB with `data_rdy[1]`=0 at timestamp 37. Required, one cycle later: `err_sticky`=4'b0010, `viol_cnt[1]`=1, `first_err_port`=1, `first_err_type`=3'b001, `first_err_time`=37.
- **Simultaneous violations.** Port 3 addr and port 0 data and addr all change with ready low in the same cycle. Required: `first_err_port`=0, `first_err_type`=3'b011, `err_sticky`=4'b1001, `viol_cnt[0]`=1 (not 2).
- **Ready overrun.** MAX_RDY_CYC=8; hold `data_rdy[0]` high for 12 cycles. Required: exactly one overrun on the 9th cycle, `viol_cnt[0]`=1, `xfer_cnt[0]`=12, type bit2 set.
- **Clear and enable.** A violation and `clear` in the same cycle leave all counters at 0. With `enable`=0, violations and transfers leave the counters unchanged.
- **Reset, saturation, first cycle.** Assert `reset_n` low mid-traffic: all outputs 0. Pulse ready continuously on port 0 with CNT_W=4: `xfer_cnt[0]` stops at 15. Different data on the first cycle after reset release raises no error.
